// File: rtl/i2s_stereo_rx.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_stereo_rx
//  Purpose  : I2S / left-justified stereo receiver. Deserialises one left and
//             one right slot of SAMPLE_BITS bits (MSB first) and presents the
//             pair as a held frame with a valid/ready handshake.
//  Ports    : clk               - serial bit clock, all inputs sampled at posedge
//             reset             - asynchronous active-high reset
//             ws                - word select (0 = left, 1 = right)
//             data_in           - serial audio data
//             pcm_ready         - consumer accepts the held frame
//             err_clr           - synchronous clear of the sticky error flags
//             data_left_output  - left sample of the held frame
//             data_right_output - right sample of the held frame
//             pcm_valid         - held frame not yet consumed
//             overrun           - sticky: a completed frame was dropped
//             sync_err          - sticky: a slot ended before SAMPLE_BITS bits
//  Revision : 1.0 - initial release
// ============================================================================
module i2s_stereo_rx #(
    parameter int SAMPLE_BITS = 16,
    parameter int LJ_MODE     = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ws,
    input  logic                   data_in,
    input  logic                   pcm_ready,
    input  logic                   err_clr,
    output logic [SAMPLE_BITS-1:0] data_left_output,
    output logic [SAMPLE_BITS-1:0] data_right_output,
    output logic                   pcm_valid,
    output logic                   overrun,
    output logic                   sync_err
);

    localparam int                     c_CNT_W    = $clog2(SAMPLE_BITS + 1);
    localparam logic [c_CNT_W-1:0]     c_LAST_IDX = c_CNT_W'(SAMPLE_BITS - 1);
    localparam logic [c_CNT_W-1:0]     c_ONE      = c_CNT_W'(1);
    localparam logic [SAMPLE_BITS-1:0] c_MSB_ONE  = {1'b1, {(SAMPLE_BITS-1){1'b0}}};

    localparam logic [2:0] c_ST_SYNC    = 3'd0;
    localparam logic [2:0] c_ST_SHIFT_L = 3'd1;
    localparam logic [2:0] c_ST_HOLD_L  = 3'd2;
    localparam logic [2:0] c_ST_SHIFT_R = 3'd3;
    localparam logic [2:0] c_ST_HOLD_R  = 3'd4;

    logic                   w_eff_ws;
    logic                   w_rise;
    logic                   w_fall;
    logic [SAMPLE_BITS-1:0] w_start;
    logic [SAMPLE_BITS-1:0] w_ins;
    logic                   w_serr_ev;
    logic                   w_ovr_ev;

    logic [2:0]             r_state;
    logic                   r_eff_prev;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [SAMPLE_BITS-1:0] r_sh_l;
    logic [SAMPLE_BITS-1:0] r_sh_r;
    logic [SAMPLE_BITS-1:0] r_frm_l;
    logic [SAMPLE_BITS-1:0] r_frm_r;
    logic                   r_done;
    logic [SAMPLE_BITS-1:0] r_out_l;
    logic [SAMPLE_BITS-1:0] r_out_r;
    logic                   r_valid;
    logic                   r_ovr;
    logic                   r_serr;

    // Philips framing: the slot MSB follows the ws transition by one clock, so
    // word select is re-timed by one clock to line up with its data.
    generate
        if (LJ_MODE != 0) begin : g_lj
            assign w_eff_ws = ws;
        end else begin : g_philips
            logic r_ws_d;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_ws_d <= 1'b0;
                end else begin
                    r_ws_d <= ws;
                end
            end
            assign w_eff_ws = r_ws_d;
        end
    endgenerate

    assign w_rise = ~r_eff_prev &  w_eff_ws;
    assign w_fall =  r_eff_prev & ~w_eff_ws;

    // Bits are placed directly at their final left-aligned position, so a
    // short slot is already MSB-aligned with zero LSBs.
    assign w_start = data_in ? c_MSB_ONE : '0;
    assign w_ins   = data_in ? (c_MSB_ONE >> r_cnt) : '0;

    assign w_serr_ev = ((r_state == c_ST_SHIFT_L) && w_rise) ||
                       ((r_state == c_ST_SHIFT_R) && w_fall);
    assign w_ovr_ev  = r_done & r_valid & ~pcm_ready;

    // Slot sequencer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_ST_SYNC;
            r_eff_prev <= 1'b0;
            r_cnt      <= '0;
            r_sh_l     <= '0;
            r_sh_r     <= '0;
            r_frm_l    <= '0;
            r_frm_r    <= '0;
            r_done     <= 1'b0;
        end else begin
            r_eff_prev <= w_eff_ws;
            r_done     <= 1'b0;
            case (r_state)
                c_ST_SYNC: begin
                    if (w_fall) begin
                        r_state <= c_ST_SHIFT_L;
                        r_sh_l  <= w_start;
                        r_cnt   <= c_ONE;
                    end
                end
                c_ST_SHIFT_L: begin
                    if (w_rise) begin
                        r_state <= c_ST_SHIFT_R;
                        r_sh_r  <= w_start;
                        r_cnt   <= c_ONE;
                    end else begin
                        r_sh_l <= r_sh_l | w_ins;
                        if (r_cnt == c_LAST_IDX) begin
                            r_state <= c_ST_HOLD_L;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_ONE;
                        end
                    end
                end
                c_ST_HOLD_L: begin
                    if (w_rise) begin
                        r_state <= c_ST_SHIFT_R;
                        r_sh_r  <= w_start;
                        r_cnt   <= c_ONE;
                    end
                end
                c_ST_SHIFT_R: begin
                    if (w_fall) begin
                        // Short right slot: the frame closes now and the
                        // edge bit opens the next left slot, so snapshot
                        // before the left register is restarted.
                        r_frm_l <= r_sh_l;
                        r_frm_r <= r_sh_r;
                        r_done  <= 1'b1;
                        r_state <= c_ST_SHIFT_L;
                        r_sh_l  <= w_start;
                        r_cnt   <= c_ONE;
                    end else begin
                        r_sh_r <= r_sh_r | w_ins;
                        if (r_cnt == c_LAST_IDX) begin
                            r_frm_l <= r_sh_l;
                            r_frm_r <= r_sh_r | w_ins;
                            r_done  <= 1'b1;
                            r_state <= c_ST_HOLD_R;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_ONE;
                        end
                    end
                end
                c_ST_HOLD_R: begin
                    if (w_fall) begin
                        r_state <= c_ST_SHIFT_L;
                        r_sh_l  <= w_start;
                        r_cnt   <= c_ONE;
                    end
                end
                default: begin
                    r_state <= c_ST_SYNC;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Output frame buffer and sticky error flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_l <= '0;
            r_out_r <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
            r_serr  <= 1'b0;
        end else begin
            if (r_done) begin
                if (!r_valid || pcm_ready) begin
                    r_out_l <= r_frm_l;
                    r_out_r <= r_frm_r;
                    r_valid <= 1'b1;
                end
            end else if (r_valid && pcm_ready) begin
                r_valid <= 1'b0;
            end
            // A fresh error event outranks a simultaneous clear.
            r_ovr  <= w_ovr_ev  | (r_ovr  & ~err_clr);
            r_serr <= w_serr_ev | (r_serr & ~err_clr);
        end
    end

    assign data_left_output  = r_out_l;
    assign data_right_output = r_out_r;
    assign pcm_valid         = r_valid;
    assign overrun           = r_ovr;
    assign sync_err          = r_serr;

endmodule
`default_nettype wire

// File: tb/tb_i2s_stereo_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2s_stereo_rx
//  Purpose  : Self-checking bench for i2s_stereo_rx. Drives a Philips-mode and
//             a left-justified instance with the same effective slot stream and
//             compares both against a slot-level reference model every cycle,
//             plus literal expectations for the directed scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_stereo_rx;

    localparam int SB = 16;

    logic          clk = 1'b0;
    logic          reset, ws_pi, ws_lj, data_in, pcm_ready, err_clr;
    logic [SB-1:0] l_pi, r_pi, l_lj, r_lj;
    logic          v_pi, v_lj, o_pi, o_lj, s_pi, s_lj;

    always #5 clk = ~clk;

    i2s_stereo_rx #(.SAMPLE_BITS(SB), .LJ_MODE(0)) u_dut_pi (
        .clk(clk), .reset(reset), .ws(ws_pi), .data_in(data_in),
        .pcm_ready(pcm_ready), .err_clr(err_clr),
        .data_left_output(l_pi), .data_right_output(r_pi),
        .pcm_valid(v_pi), .overrun(o_pi), .sync_err(s_pi));

    i2s_stereo_rx #(.SAMPLE_BITS(SB), .LJ_MODE(1)) u_dut_lj (
        .clk(clk), .reset(reset), .ws(ws_lj), .data_in(data_in),
        .pcm_ready(pcm_ready), .err_clr(err_clr),
        .data_left_output(l_lj), .data_right_output(r_lj),
        .pcm_valid(v_lj), .overrun(o_lj), .sync_err(s_lj));

    // ---------------- stimulus stream (effective word select per cycle) -----
    bit q_eff[$], q_dat[$], q_rdy[$], q_clr[$], q_rst[$];
    bit g_rdy, g_rst;

    task automatic push(input bit e, input bit d);
        q_eff.push_back(e); q_dat.push_back(d);
        q_rdy.push_back(g_rdy); q_clr.push_back(1'b0); q_rst.push_back(g_rst);
    endtask

    task automatic slot(input bit e, input int len, input logic [31:0] val, input int nb);
        for (int i = 0; i < len; i++) push(e, (i < nb) ? val[nb-1-i] : 1'b0);
    endtask

    // ---------------- reference model (index 0 = Philips, 1 = left-justified)
    bit          m_pws[2], m_peff[2], m_sync[2], m_chan[2], m_done[2];
    bit          m_v[2], m_ovr[2], m_serr[2];
    int          m_n[2];
    logic [SB-1:0] m_acc[2], m_left[2], m_fl[2], m_fr[2], m_ol[2], m_or[2];

    task automatic m_reset(input int m);
        m_pws[m] = 0; m_peff[m] = 0; m_sync[m] = 0; m_chan[m] = 0; m_done[m] = 0;
        m_v[m] = 0; m_ovr[m] = 0; m_serr[m] = 0; m_n[m] = 0;
        m_acc[m] = '0; m_left[m] = '0; m_fl[m] = '0; m_fr[m] = '0; m_ol[m] = '0; m_or[m] = '0;
    endtask

    // A finished slot: left value is remembered, a right value completes a frame.
    task automatic m_record(input int m);
        if (m_chan[m] == 1'b0) m_left[m] = m_acc[m];
        else begin
            m_fl[m] = m_left[m]; m_fr[m] = m_acc[m]; m_done[m] = 1;
        end
    endtask

    task automatic m_step(input int m, input bit w, input bit d, input bit rdy, input bit clr);
        bit eff, ev_o, ev_s;
        ev_o = 0; ev_s = 0;
        if (m_done[m]) begin
            if (!m_v[m] || rdy) begin m_ol[m] = m_fl[m]; m_or[m] = m_fr[m]; m_v[m] = 1; end
            else ev_o = 1;
        end else if (m_v[m] && rdy) m_v[m] = 0;
        m_done[m] = 0;
        eff = (m == 1) ? w : m_pws[m];
        if (eff != m_peff[m]) begin
            if (m_sync[m] && m_n[m] < SB) begin ev_s = 1; m_record(m); end
            if (m_sync[m] || !eff) begin
                m_sync[m] = 1; m_chan[m] = eff; m_acc[m] = '0; m_acc[m][SB-1] = d; m_n[m] = 1;
            end
        end else if (m_sync[m] && m_n[m] < SB) begin
            m_acc[m][SB-1-m_n[m]] = d;
            m_n[m]++;
            if (m_n[m] == SB) m_record(m);
        end
        m_ovr[m]  = ev_o | (m_ovr[m]  & !clr);
        m_serr[m] = ev_s | (m_serr[m] & !clr);
        m_pws[m] = w; m_peff[m] = eff;
    endtask

    // ---------------- checking ----------------------------------------------
    int n_chk = 0, n_fail = 0, cyc = 0;
    int first_v_pi = -1, first_v_lj = -1, mk_rst = -1;
    logic [SB-1:0] snap_l_pi, snap_r_pi, snap_l_lj, snap_r_lj;
    logic          snap_v_pi;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic cmp_models();
        chk("pi_left",  32'(l_pi), 32'(m_ol[0]));  chk("pi_right", 32'(r_pi), 32'(m_or[0]));
        chk("pi_valid", 32'(v_pi), 32'(m_v[0]));   chk("pi_ovr",   32'(o_pi), 32'(m_ovr[0]));
        chk("pi_serr",  32'(s_pi), 32'(m_serr[0]));
        chk("lj_left",  32'(l_lj), 32'(m_ol[1]));  chk("lj_right", 32'(r_lj), 32'(m_or[1]));
        chk("lj_valid", 32'(v_lj), 32'(m_v[1]));   chk("lj_ovr",   32'(o_lj), 32'(m_ovr[1]));
        chk("lj_serr",  32'(s_lj), 32'(m_serr[1]));
    endtask

    task automatic run_to(input int n);
        while (cyc < n) begin
            @(negedge clk);
            reset     = q_rst[cyc];
            ws_lj     = q_eff[cyc];
            ws_pi     = (cyc + 1 < q_eff.size()) ? q_eff[cyc+1] : q_eff[cyc];
            data_in   = q_dat[cyc];
            pcm_ready = q_rdy[cyc];
            err_clr   = q_clr[cyc];
            #1;
            if (reset) begin
                m_reset(0); m_reset(1); cmp_models();
                if (cyc == mk_rst) begin
                    snap_l_pi = l_pi; snap_r_pi = r_pi; snap_l_lj = l_lj; snap_r_lj = r_lj;
                    snap_v_pi = v_pi;
                end
            end
            @(posedge clk);
            if (!reset) begin
                m_step(0, ws_pi, data_in, pcm_ready, err_clr);
                m_step(1, ws_lj, data_in, pcm_ready, err_clr);
            end
            #1;
            cmp_models();
            if (v_pi && first_v_pi < 0) first_v_pi = cyc;
            if (v_lj && first_v_lj < 0) first_v_lj = cyc;
            cyc++;
        end
    endtask

    int mk_rise, mk_a, mk_b, mk_clr, mk_c, mk_r, mk_d, mk_e, mk_clr2, mk_f;

    initial begin
        reset = 1'b1; ws_pi = 1'b0; ws_lj = 1'b0; data_in = 1'b0;
        pcm_ready = 1'b0; err_clr = 1'b0;
        m_reset(0); m_reset(1);

        // Nominal frame A5C3 / 1234 after reset and a stretch of ignored right slot
        g_rdy = 1; g_rst = 1; slot(1, 3, 0, 0); g_rst = 0;
        slot(1, 4, 0, 0);
        slot(0, 32, 32'hA5C3, SB);
        mk_rise = q_eff.size(); slot(1, 32, 32'h1234, SB); mk_a = q_eff.size();
        // Consumer stalled across two frames
        g_rdy = 0;
        slot(0, 32, 32'h1111, SB); slot(1, 32, 32'h2222, SB);
        slot(0, 32, 32'h3333, SB); slot(1, 32, 32'h4444, SB);
        slot(0, 20, 32'h5555, SB); mk_b = q_eff.size();
        mk_clr = q_eff.size(); slot(0, 12, 0, 0); q_clr[mk_clr] = 1; mk_c = q_eff.size();
        // Ready exactly on the load posedge of the next frame
        mk_r = q_eff.size(); slot(1, 32, 32'h6666, SB); q_rdy[mk_r+16] = 1; mk_d = q_eff.size();
        // Short 10-clock left slot of ones
        g_rdy = 1; slot(0, 10, 32'h3FF, 10); slot(1, 32, 32'hBEEF, SB); mk_e = q_eff.size();
        // Reset in the middle of a right slot
        g_rdy = 0; mk_clr2 = q_eff.size(); slot(0, 32, 32'h7777, SB); q_clr[mk_clr2] = 1;
        slot(1, 8, 32'hFF, 8);
        g_rst = 1; mk_rst = q_eff.size(); slot(1, 2, 0, 0); g_rst = 0;
        slot(1, 22, 0, 0);
        slot(0, 32, 32'h8888, SB); slot(1, 32, 32'h9999, SB); slot(0, 4, 0, 0);
        mk_f = q_eff.size();
        // Randomised slots: mostly nominal lengths, some short, random data,
        // random ready, occasional error clear and reset
        begin
            bit e;
            e = 0;
            for (int s = 0; s < 170; s++) begin
                int len;
                len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, SB-1))
                                                  : int'($urandom_range(SB, SB+6));
                for (int i = 0; i < len; i++) begin
                    g_rdy = ($urandom_range(0, 2) != 0);
                    g_rst = ($urandom_range(0, 399) == 0);
                    push(e, ($urandom_range(0, 1) == 1));
                    if ($urandom_range(0, 24) == 0) q_clr[q_clr.size()-1] = 1;
                end
                e = ~e;
            end
            g_rst = 0;
        end

        run_to(3);
        chk("rst_left_pi",  32'(l_pi), 32'h0);
        chk("rst_valid_pi", 32'(v_pi), 32'h0);
        chk("rst_ovr_lj",   32'(o_lj), 32'h0);

        run_to(mk_a);
        chk("lat_pi_vs_ws", 32'(first_v_pi - (mk_rise - 1)), 32'd17);
        chk("lat_lj_vs_ws", 32'(first_v_lj - mk_rise), 32'd16);
        chk("a_left_pi",  32'(l_pi), 32'hA5C3); chk("a_right_pi", 32'(r_pi), 32'h1234);
        chk("a_left_lj",  32'(l_lj), 32'hA5C3); chk("a_right_lj", 32'(r_lj), 32'h1234);

        run_to(mk_b);
        chk("b_left_pi",  32'(l_pi), 32'h1111); chk("b_right_pi", 32'(r_pi), 32'h2222);
        chk("b_valid_pi", 32'(v_pi), 32'h1);    chk("b_ovr_pi",   32'(o_pi), 32'h1);
        chk("b_ovr_lj",   32'(o_lj), 32'h1);

        run_to(mk_c);
        chk("c_ovr_pi",  32'(o_pi), 32'h0); chk("c_ovr_lj", 32'(o_lj), 32'h0);
        chk("c_left_pi", 32'(l_pi), 32'h1111);

        run_to(mk_d);
        chk("d_left_pi",  32'(l_pi), 32'h5555); chk("d_right_pi", 32'(r_pi), 32'h6666);
        chk("d_valid_pi", 32'(v_pi), 32'h1);    chk("d_ovr_pi",   32'(o_pi), 32'h0);

        run_to(mk_e);
        chk("e_left_pi", 32'(l_pi), 32'hFFC0); chk("e_right_pi", 32'(r_pi), 32'hBEEF);
        chk("e_serr_pi", 32'(s_pi), 32'h1);    chk("e_left_lj",  32'(l_lj), 32'hFFC0);
        chk("e_serr_lj", 32'(s_lj), 32'h1);

        run_to(mk_f);
        chk("f_rst_left_pi",  32'(snap_l_pi), 32'h0); chk("f_rst_right_pi", 32'(snap_r_pi), 32'h0);
        chk("f_rst_left_lj",  32'(snap_l_lj), 32'h0); chk("f_rst_right_lj", 32'(snap_r_lj), 32'h0);
        chk("f_rst_valid_pi", 32'(snap_v_pi), 32'h0);
        chk("f_left_pi", 32'(l_pi), 32'h8888); chk("f_right_pi", 32'(r_pi), 32'h9999);
        chk("f_left_lj", 32'(l_lj), 32'h8888); chk("f_valid_lj", 32'(v_lj), 32'h1);
        chk("f_ovr_pi",  32'(o_pi), 32'h0);    chk("f_serr_pi",  32'(s_pi), 32'h0);

        run_to(q_eff.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
